// File: rtl/game_state_ctrl.sv
// game_state_ctrl
//   Top-level game sequencer. Owns the start-screen menu and the
//   countdown / capture / play / result phases, timing the countdown and
//   result phases in video frames and issuing a one-cycle camera trigger.
//
// Ports
//   clk_in           system clock
//   rst_in           synchronous active-high reset
//   sw_state         game enable switch; 0 forces IDLE
//   left_in          debounced level, menu left
//   right_in         debounced level, menu right
//   middle_in        debounced level, confirm / skip
//   new_frame_in     1-cycle pulse at start of each video frame
//   state_1_over_in  start_screen done flag (level)
//   cam_done_in      1-cycle pulse, capture buffer filled
//   game_over_in     1-cycle pulse from play logic
//   state_out        current FSM state encoding
//   select_out       menu selection / committed selection
//   start_en_out     high while in START
//   capture_trig_out 1-cycle camera capture request
//   frame_cnt_out    frames elapsed in current timed state (saturates 255)
module game_state_ctrl #(
  parameter int NUM_OPTIONS   = 5,
  parameter int COUNT_FRAMES  = 90,
  parameter int RESULT_FRAMES = 180
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       sw_state,
  input  logic       left_in,
  input  logic       right_in,
  input  logic       middle_in,
  input  logic       new_frame_in,
  input  logic       state_1_over_in,
  input  logic       cam_done_in,
  input  logic       game_over_in,
  output logic [2:0] state_out,
  output logic [2:0] select_out,
  output logic       start_en_out,
  output logic       capture_trig_out,
  output logic [7:0] frame_cnt_out
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    COUNTDOWN = 3'd2,
    CAPTURE   = 3'd3,
    PLAY      = 3'd4,
    RESULT    = 3'd5
  } state_t;

  localparam logic [2:0] MAX_SEL = 3'(NUM_OPTIONS - 1);
  localparam logic [8:0] CNT_END = 9'(COUNT_FRAMES);
  localparam logic [8:0] RES_END = 9'(RESULT_FRAMES);

  state_t     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] cnt_q, cnt_d;
  logic       trig_q, trig_d;
  logic       start_en_q;

  logic left_prev_q, right_prev_q, middle_prev_q;
  logic left_e_q, right_e_q, middle_e_q;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // True when the pending frame pulse brings the count up to the limit.
  function automatic logic hits(input logic [7:0] v, input logic [8:0] lim);
    return ({1'b0, v} + 9'd1) >= lim;
  endfunction

  // Previous-level registers follow the inputs even during reset, so a
  // button already held when reset releases never looks like a new press.
  always_ff @(posedge clk_in) begin
    left_prev_q   <= left_in;
    right_prev_q  <= right_in;
    middle_prev_q <= middle_in;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      left_e_q   <= 1'b0;
      right_e_q  <= 1'b0;
      middle_e_q <= 1'b0;
    end else begin
      left_e_q   <= left_in   & ~left_prev_q;
      right_e_q  <= right_in  & ~right_prev_q;
      middle_e_q <= middle_in & ~middle_prev_q;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = 8'd0;   // counter reads 0 outside timed states and on entry
    trig_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (sw_state) state_d = START;
      end
      START: begin
        if (middle_e_q || state_1_over_in) begin
          state_d = COUNTDOWN;
        end else if (left_e_q && !right_e_q) begin
          sel_d = (sel_q == 3'd0) ? MAX_SEL : sel_q - 3'd1;
        end else if (right_e_q && !left_e_q) begin
          sel_d = (sel_q >= MAX_SEL) ? 3'd0 : sel_q + 3'd1;
        end
      end
      COUNTDOWN: begin
        if (new_frame_in) begin
          if (hits(cnt_q, CNT_END)) begin
            state_d = CAPTURE;
            trig_d  = 1'b1;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      CAPTURE: begin
        if (cam_done_in) state_d = PLAY;
      end
      PLAY: begin
        if (game_over_in) state_d = RESULT;
      end
      RESULT: begin
        if (middle_e_q) begin
          state_d = START;
        end else if (new_frame_in) begin
          if (hits(cnt_q, RES_END)) state_d = START;
          else                      cnt_d   = sat_inc(cnt_q);
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: state_d = IDLE;
    endcase
    // Switch off overrides every transition; selection is kept.
    if (!sw_state) begin
      state_d = IDLE;
      cnt_d   = 8'd0;
      trig_d  = 1'b0;
      sel_d   = sel_q;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      sel_q      <= 3'd0;
      cnt_q      <= 8'd0;
      trig_q     <= 1'b0;
      start_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      trig_q     <= trig_d;
      start_en_q <= (state_d == START);
    end
  end

  assign state_out        = state_q;
  assign select_out       = sel_q;
  assign start_en_out     = start_en_q;
  assign capture_trig_out = trig_q;
  assign frame_cnt_out    = cnt_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
module tb_game_state_ctrl;

  logic       clk = 1'b0;
  logic       rst, sw, left, right, middle, nf, s1o, cam, gover;
  logic [2:0] state, sel;
  logic       sen, trig;
  logic [7:0] fcnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  game_state_ctrl dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .sw_state        (sw),
    .left_in         (left),
    .right_in        (right),
    .middle_in       (middle),
    .new_frame_in    (nf),
    .state_1_over_in (s1o),
    .cam_done_in     (cam),
    .game_over_in    (gover),
    .state_out       (state),
    .select_out      (sel),
    .start_en_out    (sen),
    .capture_trig_out(trig),
    .frame_cnt_out   (fcnt)
  );

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Level high for one cycle, then low; returns once the action has landed.
  task automatic press(input bit l, input bit r, input bit m);
    @(negedge clk);
    left = l; right = r; middle = m;
    @(negedge clk);
    left = 1'b0; right = 1'b0; middle = 1'b0;
    @(negedge clk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); nf = 1'b1;
      @(negedge clk); nf = 1'b0;
    end
  endtask

  task automatic pulse_cam;
    @(negedge clk); cam = 1'b1;
    @(negedge clk); cam = 1'b0;
  endtask

  task automatic pulse_gover;
    @(negedge clk); gover = 1'b1;
    @(negedge clk); gover = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sw = 1'b0; left = 1'b0; right = 1'b0; middle = 1'b0;
    nf = 1'b0; s1o = 1'b0; cam = 1'b0; gover = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", state, 0);
    check("rst_sel",   sel,   0);
    check("rst_sen",   sen,   0);
    check("rst_trig",  trig,  0);
    check("rst_cnt",   fcnt,  0);

    // Enable from reset: IDLE first, then START.
    sw = 1'b1;
    rst = 1'b0;
    check("idle_after_rst", state, 0);
    @(negedge clk);
    check("to_start", state, 1);
    check("start_en", sen, 1);
    check("start_sel0", sel, 0);

    // Menu steering with wrap.
    press(1, 0, 0);
    check("left_wrap", sel, 4);
    press(0, 1, 0);
    check("right_wrap", sel, 0);
    press(0, 1, 0);
    check("right_inc", sel, 1);
    press(1, 1, 0);
    check("lr_same", sel, 1);
    cam = 1'b1; @(negedge clk); cam = 1'b0; @(negedge clk);
    check("cam_ignored_start", state, 1);

    // Middle beats simultaneous left -> COUNTDOWN, selection frozen.
    press(1, 0, 1);
    check("mid_to_cd", state, 2);
    check("mid_sel_kept", sel, 1);
    check("cd_cnt0", fcnt, 0);
    check("cd_sen", sen, 0);
    frames(89);
    check("cd_cnt89", fcnt, 89);
    check("cd_state89", state, 2);
    check("cd_notrig", trig, 0);
    frames(1);
    check("capture_state", state, 3);
    check("trig_hi", trig, 1);
    @(negedge clk);
    check("trig_one_cycle", trig, 0);
    check("capture_hold", state, 3);

    pulse_gover;
    check("gover_ignored_cap", state, 3);
    pulse_cam;
    check("play", state, 4);
    pulse_gover;
    check("result", state, 5);
    check("res_cnt0", fcnt, 0);
    frames(179);
    check("res_cnt179", fcnt, 179);
    check("res_state179", state, 5);
    frames(1);
    check("res_to_start", state, 1);
    check("res_sel_kept", sel, 1);
    check("res_sen", sen, 1);
    check("res_cnt_clr", fcnt, 0);

    // start_screen done flag also starts the countdown.
    @(negedge clk); s1o = 1'b1;
    @(negedge clk); s1o = 1'b0;
    check("s1o_to_cd", state, 2);

    // Switch off mid-countdown.
    frames(40);
    check("cd_cnt40", fcnt, 40);
    @(negedge clk); sw = 1'b0;
    @(negedge clk);
    check("sw_off_idle", state, 0);
    check("sw_off_cnt", fcnt, 0);
    check("sw_off_trig", trig, 0);
    check("sw_off_sel", sel, 1);
    sw = 1'b1;
    @(negedge clk);
    check("sw_on_start", state, 1);

    // Middle edge in RESULT skips back to START.
    press(0, 0, 1);
    frames(90);
    pulse_cam;
    pulse_gover;
    check("result2", state, 5);
    frames(3);
    press(0, 0, 1);
    check("res_mid_skip", state, 1);

    // Reset mid-operation while the middle button is held.
    press(0, 1, 0);
    check("sel_before_rst", sel, 2);
    @(negedge clk); middle = 1'b1;
    do_reset;
    check("rst_mid_state", state, 0);
    check("rst_mid_sel", sel, 0);
    repeat (4) @(negedge clk);
    check("held_no_edge", state, 1);
    middle = 1'b0;
    @(negedge clk);
    check("release_no_edge", state, 1);
    press(0, 0, 1);
    check("repress_cd", state, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
